// File: rtl/tm_sch_pio_master.sv
// PIO bus initiator for the traffic-manager scheduler memories: decodes a host
// request into one of six memory selects, strobes it, waits for the ack (or a timeout) and responds.
module tm_sch_pio_master #(
  parameter int REGION_LSB     = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_NBITS       = 8,
  parameter int PIO_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             host_req,
  input  logic             host_wr,
  input  logic [PIO_W-1:0] host_addr,
  input  logic [PIO_W-1:0] host_wdata,
  output logic             host_ready,
  output logic             host_rsp_valid,
  output logic [PIO_W-1:0] host_rdata,
  output logic             host_err,
  output logic [PIO_W-1:0] reg_addr,
  output logic [PIO_W-1:0] reg_din,
  output logic             reg_rd,
  output logic             reg_wr,
  output logic             reg_ms_queue_profile,
  output logic             reg_ms_wdrr_quantum,
  output logic             reg_ms_shaping_profile_cir,
  output logic             reg_ms_shaping_profile_eir,
  output logic             reg_ms_wdrr_sch_ctrl,
  output logic             reg_ms_fill_tb_dst,
  input  logic             queue_profile_mem_ack,
  input  logic             wdrr_quantum_mem_ack,
  input  logic             shaping_profile_cir_mem_ack,
  input  logic             shaping_profile_eir_mem_ack,
  input  logic             wdrr_sch_ctrl_mem_ack,
  input  logic             fill_tb_dst_mem_ack,
  input  logic [PIO_W-1:0] queue_profile_mem_rdata,
  input  logic [PIO_W-1:0] wdrr_quantum_mem_rdata,
  input  logic [PIO_W-1:0] shaping_profile_cir_mem_rdata,
  input  logic [PIO_W-1:0] shaping_profile_eir_mem_rdata,
  input  logic [PIO_W-1:0] wdrr_sch_ctrl_mem_rdata,
  input  logic [PIO_W-1:0] fill_tb_dst_mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_ACK = 2'd2, RESP = 2'd3} state_t;

  localparam logic [PIO_W-1:0]    ERR_DATA = PIO_W'(32'hDEAD_BEEF);
  localparam logic [TO_NBITS-1:0] TO_LAST  = TO_NBITS'(TIMEOUT_CYCLES - 1);

  // Region code to one-hot memory select; unmapped regions select nothing.
  function automatic logic [5:0] region_onehot(input logic [2:0] region);
    logic [5:0] sel;
    case (region)
      3'd0:    sel = 6'b000001;
      3'd1:    sel = 6'b000010;
      3'd2:    sel = 6'b000100;
      3'd3:    sel = 6'b001000;
      3'd4:    sel = 6'b010000;
      3'd5:    sel = 6'b100000;
      default: sel = 6'b000000;
    endcase
    return sel;
  endfunction

  state_t              state_r, state_s;
  logic [5:0]          sel_r;
  logic                wr_r;
  logic [PIO_W-1:0]    addr_r, din_r, rdata_r;
  logic                err_r;
  logic [TO_NBITS-1:0] cnt_r;

  logic [2:0]          region_s;
  logic                dec_err_s;
  logic [5:0]          ack_vec_s;
  logic                sel_ack_s;
  logic                timeout_s;
  logic [PIO_W-1:0]    mem_rdata_s;

  assign region_s  = host_addr[REGION_LSB+2 -: 3];
  assign dec_err_s = (region_s > 3'd5);
  assign ack_vec_s = {fill_tb_dst_mem_ack, wdrr_sch_ctrl_mem_ack, shaping_profile_eir_mem_ack,
                      shaping_profile_cir_mem_ack, wdrr_quantum_mem_ack, queue_profile_mem_ack};
  assign sel_ack_s = |(ack_vec_s & sel_r);
  assign timeout_s = (cnt_r == TO_LAST);

  // Read-data mux keyed by the latched select.
  always_comb begin
    mem_rdata_s = '0;
    case (sel_r)
      6'b000001: mem_rdata_s = queue_profile_mem_rdata;
      6'b000010: mem_rdata_s = wdrr_quantum_mem_rdata;
      6'b000100: mem_rdata_s = shaping_profile_cir_mem_rdata;
      6'b001000: mem_rdata_s = shaping_profile_eir_mem_rdata;
      6'b010000: mem_rdata_s = wdrr_sch_ctrl_mem_rdata;
      6'b100000: mem_rdata_s = fill_tb_dst_mem_rdata;
      default:   mem_rdata_s = '0;
    endcase
  end

  // Next-state logic; an ack wins over a simultaneous timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (host_req) state_s = dec_err_s ? RESP : ISSUE;
        else          state_s = IDLE;
      end
      ISSUE: begin
        if (clk_div) state_s = WAIT_ACK;
        else         state_s = ISSUE;
      end
      WAIT_ACK: begin
        if (sel_ack_s || timeout_s) state_s = RESP;
        else                        state_s = WAIT_ACK;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, holding registers, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= 6'b000000;
      wr_r    <= 1'b0;
      addr_r  <= '0;
      din_r   <= '0;
      rdata_r <= '0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (host_req) begin
            addr_r <= host_addr;
            din_r  <= host_wdata;
            wr_r   <= host_wr;
            sel_r  <= region_onehot(region_s);
            if (dec_err_s) begin
              rdata_r <= ERR_DATA;
              err_r   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (clk_div) cnt_r <= '0;
        end
        WAIT_ACK: begin
          if (sel_ack_s) begin
            rdata_r <= wr_r ? '0 : mem_rdata_s;
            err_r   <= 1'b0;
          end else if (timeout_s) begin
            rdata_r <= ERR_DATA;
            err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + TO_NBITS'(1);
          end
        end
        RESP: begin
          sel_r   <= 6'b000000;
          rdata_r <= '0;
          err_r   <= 1'b0;
        end
        default: sel_r <= 6'b000000;
      endcase
    end
  end

  assign host_ready     = (state_r == IDLE);
  assign host_rsp_valid = (state_r == RESP);
  assign host_rdata     = rdata_r;
  assign host_err       = err_r;
  assign reg_addr       = addr_r;
  assign reg_din        = din_r;
  // Strobes qualify on clk_div in the same cycle so the earliest strobe lands right after accept.
  assign reg_rd         = (state_r == ISSUE) && clk_div && !wr_r;
  assign reg_wr         = (state_r == ISSUE) && clk_div && wr_r;

  assign reg_ms_queue_profile       = sel_r[0];
  assign reg_ms_wdrr_quantum        = sel_r[1];
  assign reg_ms_shaping_profile_cir = sel_r[2];
  assign reg_ms_shaping_profile_eir = sel_r[3];
  assign reg_ms_wdrr_sch_ctrl       = sel_r[4];
  assign reg_ms_fill_tb_dst         = sel_r[5];

endmodule
